// File: rtl/serdes_frame_rx_crc.sv
// SerDes frame receiver: strips SOF/EOF, checks the trailing CRC-16/CCITT and forwards payload
// with a two-byte lag. Defining SERDES_FRAME_STAT_EN adds good/bad frame counters.
//   state   | meaning
//   IDLE    | waiting for SOF, every other byte ignored
//   BODY    | inside a frame, data bytes pass through the 2-byte holding line
//   DISCARD | frame already failed, drop bytes until EOF or SOF
module serdes_frame_rx_crc #(
    parameter int unsigned MAX_LEN  = 1024,
    parameter logic [7:0]  SOF_CHAR = 8'hFB,
    parameter logic [7:0]  EOF_CHAR = 8'hFD
) (
    input  logic        S_CLK_I,
    input  logic        S_RST_I,
    input  logic [7:0]  RX_DATA_I,
    input  logic        RX_K_I,
    input  logic        RX_VALID_I,
    output logic [7:0]  S_DATA_O,
    output logic        S_WR_EN_O,
    output logic        S_SUCC_O,
    output logic        S_FAIL_O,
    input  logic        S_READY_I
`ifdef SERDES_FRAME_STAT_EN
    ,
    output logic [15:0] STAT_GOOD_O,
    output logic [15:0] STAT_BAD_O
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BODY    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    localparam logic [15:0] LP_MAX_LEN = 16'(MAX_LEN);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_crc;
    logic [15:0] r_len;
    logic [7:0]  r_hold_old;
    logic [7:0]  r_hold_new;
    logic [1:0]  r_hcnt;
    logic [7:0]  r_data;
    logic        r_wr_en;
    logic        r_succ;
    logic        r_fail;

    logic        w_sof;
    logic        w_eof;
    logic        w_k_other;
    logic        w_data;
    logic        w_in_body;
    logic        w_emit_due;
    logic        w_emit_ok;
    logic        w_frame_good;
    logic        w_push;
    logic        w_wr_next;
    logic        w_succ_next;
    logic        w_fail_next;
    logic [15:0] w_crc_next;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
            else              r = {r[14:0], 1'b0};
        end
        return r;
    endfunction

    assign w_sof      = RX_VALID_I & RX_K_I & (RX_DATA_I == SOF_CHAR);
    assign w_eof      = RX_VALID_I & RX_K_I & (RX_DATA_I == EOF_CHAR);
    assign w_k_other  = RX_VALID_I & RX_K_I & ~w_sof & ~w_eof;
    assign w_data     = RX_VALID_I & ~RX_K_I;
    assign w_in_body  = (r_state == ST_BODY);
    assign w_emit_due = w_in_body & w_data & (r_hcnt == 2'd2);
    // An emission needs both a ready sink and room under the length limit.
    assign w_emit_ok  = w_emit_due & S_READY_I & (r_len != LP_MAX_LEN);
    // CRC over payload plus its own CRC field leaves a zero residue.
    assign w_frame_good = (r_hcnt == 2'd2) && (r_len != 16'd0) && (r_crc == 16'h0000);
    assign w_crc_next   = crc16_byte(r_crc, RX_DATA_I);

    always_ff @(posedge S_CLK_I) begin
        if (S_RST_I) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sof) w_next_state = ST_BODY;
            end
            ST_BODY: begin
                if (w_sof)                          w_next_state = ST_BODY;
                else if (w_eof)                     w_next_state = ST_IDLE;
                else if (w_k_other)                 w_next_state = ST_DISCARD;
                else if (w_emit_due && !w_emit_ok)  w_next_state = ST_DISCARD;
            end
            ST_DISCARD: begin
                if (w_sof)      w_next_state = ST_BODY;
                else if (w_eof) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push      = w_in_body & w_data;
        w_wr_next   = w_emit_ok;
        w_succ_next = w_in_body & w_eof & w_frame_good;
        w_fail_next = w_in_body & (w_sof | (w_eof & ~w_frame_good) | w_k_other
                                   | (w_emit_due & ~w_emit_ok));
    end

    always_ff @(posedge S_CLK_I) begin
        if (S_RST_I) begin
            r_crc      <= 16'hFFFF;
            r_len      <= 16'd0;
            r_hold_old <= 8'd0;
            r_hold_new <= 8'd0;
            r_hcnt     <= 2'd0;
            r_data     <= 8'd0;
            r_wr_en    <= 1'b0;
            r_succ     <= 1'b0;
            r_fail     <= 1'b0;
        end else begin
            r_wr_en <= w_wr_next;
            r_succ  <= w_succ_next;
            r_fail  <= w_fail_next;
            if (w_wr_next) r_data <= r_hold_old;
            if (w_sof) begin
                r_crc      <= 16'hFFFF;
                r_len      <= 16'd0;
                r_hold_old <= 8'd0;
                r_hold_new <= 8'd0;
                r_hcnt     <= 2'd0;
            end else if (w_push) begin
                r_crc      <= w_crc_next;
                r_hold_new <= RX_DATA_I;
                r_hold_old <= r_hold_new;
                if (r_hcnt != 2'd2) r_hcnt <= r_hcnt + 2'd1;
                if (w_wr_next)      r_len  <= r_len + 16'd1;
            end
        end
    end

    assign S_DATA_O  = r_data;
    assign S_WR_EN_O = r_wr_en;
    assign S_SUCC_O  = r_succ;
    assign S_FAIL_O  = r_fail;

`ifdef SERDES_FRAME_STAT_EN
    logic [15:0] r_stat_good;
    logic [15:0] r_stat_bad;

    always_ff @(posedge S_CLK_I) begin
        if (S_RST_I) begin
            r_stat_good <= 16'd0;
            r_stat_bad  <= 16'd0;
        end else begin
            if (w_succ_next && r_stat_good != 16'hFFFF) r_stat_good <= r_stat_good + 16'd1;
            if (w_fail_next && r_stat_bad  != 16'hFFFF) r_stat_bad  <= r_stat_bad + 16'd1;
        end
    end

    assign STAT_GOOD_O = r_stat_good;
    assign STAT_BAD_O  = r_stat_bad;
`endif

endmodule

// File: tb/tb_serdes_frame_rx_crc.sv
// Bench for serdes_frame_rx_crc: two instances (default MAX_LEN and MAX_LEN=4) share one stimulus
// stream; a frame-level reference model predicts the write/succ/fail event sequence of each.
module tb_serdes_frame_rx_crc;
    localparam logic [7:0] SOF  = 8'hFB;
    localparam logic [7:0] EOF  = 8'hFD;
    localparam logic [7:0] KBAD = 8'hBC;
    localparam int EV_SUCC = 256;
    localparam int EV_FAIL = 512;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] rx_data  = 8'h00;
    logic       rx_k     = 1'b0;
    logic       rx_valid = 1'b0;
    logic       ready    = 1'b1;

    logic [7:0] d0_data, d1_data;
    logic       d0_wr, d0_succ, d0_fail;
    logic       d1_wr, d1_succ, d1_fail;
`ifdef SERDES_FRAME_STAT_EN
    logic [15:0] d0_good, d0_bad, d1_good, d1_bad;
`endif

    always #5 clk = ~clk;

    serdes_frame_rx_crc dut0 (
        .S_CLK_I(clk), .S_RST_I(rst), .RX_DATA_I(rx_data), .RX_K_I(rx_k), .RX_VALID_I(rx_valid),
        .S_DATA_O(d0_data), .S_WR_EN_O(d0_wr), .S_SUCC_O(d0_succ), .S_FAIL_O(d0_fail),
        .S_READY_I(ready)
`ifdef SERDES_FRAME_STAT_EN
        , .STAT_GOOD_O(d0_good), .STAT_BAD_O(d0_bad)
`endif
    );

    serdes_frame_rx_crc #(.MAX_LEN(4)) dut1 (
        .S_CLK_I(clk), .S_RST_I(rst), .RX_DATA_I(rx_data), .RX_K_I(rx_k), .RX_VALID_I(rx_valid),
        .S_DATA_O(d1_data), .S_WR_EN_O(d1_wr), .S_SUCC_O(d1_succ), .S_FAIL_O(d1_fail),
        .S_READY_I(ready)
`ifdef SERDES_FRAME_STAT_EN
        , .STAT_GOOD_O(d1_good), .STAT_BAD_O(d1_bad)
`endif
    );

    int checks = 0;
    int errors = 0;
    int obs0[$], obs1[$], exp0[$], exp1[$];
    int viol = 0;
    logic [7:0] last0 = 8'h00;
    logic [7:0] last1 = 8'h00;

    // Output monitor: collects events and flags exclusivity / data-hold violations.
    always @(negedge clk) begin
        if (rst) begin
            last0 = 8'h00;
            last1 = 8'h00;
        end else begin
            if (d0_wr) begin obs0.push_back(int'(d0_data)); last0 = d0_data; end
            else if (d0_data !== last0) viol++;
            if (d0_succ) obs0.push_back(EV_SUCC);
            if (d0_fail) obs0.push_back(EV_FAIL);
            if (int'(d0_wr) + int'(d0_succ) + int'(d0_fail) > 1) viol++;
            if (d1_wr) begin obs1.push_back(int'(d1_data)); last1 = d1_data; end
            else if (d1_data !== last1) viol++;
            if (d1_succ) obs1.push_back(EV_SUCC);
            if (d1_fail) obs1.push_back(EV_FAIL);
            if (int'(d1_wr) + int'(d1_succ) + int'(d1_fail) > 1) viol++;
        end
    end

    // Reference model state: 0 = outside frame, 1 = in frame, 2 = frame failed.
    int mode[2];
    int nem[2];
    int ngood[2];
    int nbad[2];
    int maxl[2] = '{1024, 4};
    logic [7:0] fb[$];
    logic [7:0] pl[$];
    int gap_mode = 0;

    function automatic logic [15:0] crc_add(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] x;
        x = c ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    function automatic bit fb_crc_ok();
        logic [15:0] c;
        int n;
        n = fb.size();
        if (n < 3) return 1'b0;
        c = 16'hFFFF;
        for (int i = 0; i < n - 2; i++) c = crc_add(c, fb[i]);
        return c == {fb[n-2], fb[n-1]};
    endfunction

    task automatic push_ev(input int m, input int ev);
        if (ev == EV_SUCC) ngood[m]++;
        if (ev == EV_FAIL) nbad[m]++;
        if (m == 0) exp0.push_back(ev);
        else        exp1.push_back(ev);
    endtask

    task automatic model_step(input logic [7:0] d, input logic k, input logic r);
        if (k && d == SOF) begin
            for (int m = 0; m < 2; m++) begin
                if (mode[m] == 1) push_ev(m, EV_FAIL);
                mode[m] = 1;
                nem[m]  = 0;
            end
            fb.delete();
        end else begin
            if (!k) fb.push_back(d);
            for (int m = 0; m < 2; m++) begin
                if (mode[m] == 1) begin
                    if (!k) begin
                        if (fb.size() >= 3) begin
                            if (!r || nem[m] == maxl[m]) begin
                                push_ev(m, EV_FAIL);
                                mode[m] = 2;
                            end else begin
                                push_ev(m, int'(fb[fb.size()-3]));
                                nem[m]++;
                            end
                        end
                    end else if (d == EOF) begin
                        push_ev(m, fb_crc_ok() ? EV_SUCC : EV_FAIL);
                        mode[m] = 0;
                    end else begin
                        push_ev(m, EV_FAIL);
                        mode[m] = 2;
                    end
                end else if (mode[m] == 2 && k && d == EOF) begin
                    mode[m] = 0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic k, input logic r);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        rx_k     = k;
        ready    = r;
        if (v) model_step(d, k, r);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [7:0] d, input logic k, input logic r);
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0))
            drive(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drive(1'b1, d, k, r);
    endtask

    // Sends SOF, pl, CRC (optionally corrupted), EOF; ready is low for data byte index rlow.
    task automatic send_frame(input bit bad, input bit eof_en, input int rlow);
        logic [15:0] c;
        int n;
        c = 16'hFFFF;
        n = pl.size();
        send(SOF, 1'b1, 1'b1);
        for (int i = 0; i < n; i++) begin
            c = crc_add(c, pl[i]);
            send(pl[i], 1'b0, i != rlow);
        end
        send(c[15:8], 1'b0, n != rlow);
        send(c[7:0] ^ {7'd0, bad}, 1'b0, (n + 1) != rlow);
        if (eof_en) send(EOF, 1'b1, 1'b1);
    endtask

    task automatic set_pl_seq(input logic [7:0] first, input int n);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'(first + 8'(i)));
    endtask

    task automatic compare(input string tag);
        chk({tag, " count0"}, obs0.size(), exp0.size());
        for (int i = 0; i < obs0.size() && i < exp0.size(); i++)
            chk($sformatf("%s ev0[%0d]", tag, i), obs0[i], exp0[i]);
        chk({tag, " count1"}, obs1.size(), exp1.size());
        for (int i = 0; i < obs1.size() && i < exp1.size(); i++)
            chk($sformatf("%s ev1[%0d]", tag, i), obs1[i], exp1[i]);
        obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " wr0"}, d0_wr, 0);
        chk({tag, " succ0"}, d0_succ, 0);
        chk({tag, " fail0"}, d0_fail, 0);
        chk({tag, " data0"}, d0_data, 0);
        chk({tag, " wr1"}, d1_wr, 0);
        chk({tag, " succ1"}, d1_succ, 0);
        chk({tag, " fail1"}, d1_fail, 0);
        chk({tag, " data1"}, d1_data, 0);
`ifdef SERDES_FRAME_STAT_EN
        chk({tag, " good0"}, d0_good, 0);
        chk({tag, " bad0"}, d0_bad, 0);
`endif
    endtask

    task automatic do_reset();
        idle(1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int m = 0; m < 2; m++) begin
            mode[m] = 0; nem[m] = 0; ngood[m] = 0; nbad[m] = 0;
        end
        fb.delete();
        @(posedge clk);
        #1;
        reset_checks("midrst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int len, rlow;
        bit bad, eofe;

        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;

        // Bytes before any SOF are ignored, then the reference good frame.
        send(8'h31, 1'b0, 1'b1);
        send(EOF, 1'b1, 1'b1);
        send(KBAD, 1'b1, 1'b1);
        send(SOF, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) send(8'(8'h31 + 8'(i)), 1'b0, 1'b1);
        send(8'h29, 1'b0, 1'b1);
        send(8'hB1, 1'b0, 1'b1);
        send(EOF, 1'b1, 1'b1);
        idle(3);
        compare("good");

        send(SOF, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) send(8'(8'h31 + 8'(i)), 1'b0, 1'b1);
        send(8'h29, 1'b0, 1'b1);
        send(8'hB0, 1'b0, 1'b1);
        send(EOF, 1'b1, 1'b1);
        idle(3);
        compare("badcrc");

        send(SOF, 1'b1, 1'b1);
        send(8'h12, 1'b0, 1'b1);
        send(8'h34, 1'b0, 1'b1);
        send(EOF, 1'b1, 1'b1);
        idle(3);
        compare("len0");

        send(SOF, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0, 1'b1);
        set_pl_seq(8'h31, 9);
        send_frame(1'b0, 1'b1, -1);
        idle(3);
        compare("sofabort");

        send_frame(1'b0, 1'b1, 5);
        idle(3);
        compare("backpressure");

        gap_mode = 1;
        send_frame(1'b0, 1'b1, -1);
        set_pl_seq(8'h41, 5);
        send_frame(1'b0, 1'b1, -1);
        gap_mode = 0;
        idle(3);
        compare("validtoggle");

        set_pl_seq(8'h51, 4);
        send_frame(1'b0, 1'b1, -1);
        set_pl_seq(8'h61, 1);
        send_frame(1'b0, 1'b1, -1);
        idle(3);
        compare("boundary");

        send(SOF, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send(8'(8'h71 + 8'(i)), 1'b0, 1'b1);
        send(KBAD, 1'b1, 1'b1);
        send(8'h74, 1'b0, 1'b1);
        send(EOF, 1'b1, 1'b1);
        idle(3);
        compare("badk");

        send(SOF, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(8'(8'h31 + 8'(i)), 1'b0, 1'b1);
        do_reset();
        for (int i = 4; i < 9; i++) send(8'(8'h31 + 8'(i)), 1'b0, 1'b1);
        send(8'h29, 1'b0, 1'b1);
        send(8'hB1, 1'b0, 1'b1);
        send(EOF, 1'b1, 1'b1);
        set_pl_seq(8'h81, 6);
        send_frame(1'b0, 1'b1, -1);
        idle(3);
        compare("resetmid");

        gap_mode = 2;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) send(8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            len = $urandom_range(0, 8);
            pl.delete();
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            bad  = ($urandom_range(0, 3) == 0);
            eofe = ($urandom_range(0, 9) != 0);
            rlow = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len + 1)) : -1;
            send_frame(bad, eofe, rlow);
        end
        gap_mode = 0;
        idle(4);
        compare("random");

        chk("protocol violations", viol, 0);
`ifdef SERDES_FRAME_STAT_EN
        chk("stat good0", d0_good, ngood[0]);
        chk("stat bad0", d0_bad, nbad[0]);
        chk("stat good1", d1_good, ngood[1]);
        chk("stat bad1", d1_bad, nbad[1]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serdes_frame_rx_crc.md
SERDES_FRAME_RX_CRC -- requirements
Module: serdes_frame_rx_crc

Interface
REQ-001 Parameter MAX_LEN, default 1024: maximum payload bytes per frame, legal range 1..65533.
REQ-002 Parameter SOF_CHAR, default 8'hFB: K-character that marks start of frame.
REQ-003 Parameter EOF_CHAR, default 8'hFD: K-character that marks end of frame.
REQ-004 S_CLK_I  in  1  the single clock; S_RST_I  in  1  reset, synchronous, active-high.
REQ-005 RX_DATA_I  in  8  decoded SerDes byte; RX_K_I  in  1  byte is a K-character; RX_VALID_I  in  1  byte qualifier.
REQ-006 S_DATA_O  out  8  payload byte to the packer stage; S_WR_EN_O  out  1  payload byte write strobe.
REQ-007 S_SUCC_O  out  1  one-cycle pulse, frame good; S_FAIL_O  out  1  one-cycle pulse, frame bad.
REQ-008 S_READY_I  in  1  downstream can accept S_WR_EN_O.
REQ-009 STAT_GOOD_O  out  16  good-frame count; STAT_BAD_O  out  16  bad-frame count; present only per REQ-030.

Function
REQ-010 The block SHALL ignore every input cycle with RX_VALID_I=0; all rules below count only valid bytes.
REQ-011 FSM states SHALL be IDLE, BODY, DISCARD.
REQ-012 IDLE: K byte equal to SOF_CHAR -> BODY, clear CRC to 16'hFFFF, clear length counter and 2-byte holding line; all other bytes ignored.
REQ-013 BODY, data byte (RX_K_I=0): update CRC-16/CCITT (poly 16'h1021, MSB first, no reflection, no xorout) with the byte, push it into the holding line; when the line already holds 2 bytes, the oldest byte SHALL be emitted.
REQ-014 Emission SHALL be registered: S_DATA_O/S_WR_EN_O valid the cycle after the pushing byte is sampled; S_WR_EN_O is high for exactly one cycle per emitted byte.
REQ-015 Length counter (16-bit) SHALL count emitted bytes; emitting byte MAX_LEN+1 SHALL instead pulse S_FAIL_O, suppress the write, and enter DISCARD.
REQ-016 BODY, EOF_CHAR: the 2 held bytes are the CRC field and SHALL NOT be written; if the holding line holds 2 bytes, the length is >=1 and the CRC register equals 16'h0000, pulse S_SUCC_O, else pulse S_FAIL_O; go to IDLE.
REQ-017 BODY, SOF_CHAR: pulse S_FAIL_O for the open frame and restart per REQ-012 in the same cycle, staying in BODY.
REQ-018 BODY, any other K byte: pulse S_FAIL_O, enter DISCARD.
REQ-019 DISCARD: no writes; EOF_CHAR -> IDLE without a further pulse; SOF_CHAR -> restart per REQ-012.
REQ-020 Backpressure: if an emission is due while S_READY_I=0, the byte SHALL be dropped, S_FAIL_O pulsed, and the FSM enter DISCARD; no byte is ever presented with S_READY_I low.
REQ-021 S_SUCC_O and S_FAIL_O SHALL share the registered timing of REQ-014, SHALL be mutually exclusive, and SHALL never coincide with S_WR_EN_O.
REQ-022 Each frame SHALL produce exactly one S_SUCC_O or S_FAIL_O pulse, and nothing after it until the next SOF_CHAR.
REQ-023 S_DATA_O SHALL hold its last value when S_WR_EN_O=0.

Reset
REQ-024 While S_RST_I=1 the FSM SHALL be in IDLE, and S_WR_EN_O, S_SUCC_O, S_FAIL_O SHALL be 0.
REQ-025 While S_RST_I=1, S_DATA_O, the holding line, and the length counter SHALL be 0, and the CRC register SHALL be 16'hFFFF.
REQ-026 Reset asserted mid-frame SHALL abandon the frame silently, with no S_FAIL_O pulse.
REQ-027 After S_RST_I is released, bytes SHALL be ignored until the next SOF_CHAR.
REQ-028 The block SHALL contain no other reset or asynchronous logic.

Configuration
REQ-029 Macro SERDES_FRAME_STAT_EN selects frame statistics.
REQ-030 With SERDES_FRAME_STAT_EN defined, STAT_GOOD_O and STAT_BAD_O SHALL exist: they increment on S_SUCC_O and S_FAIL_O respectively, saturate at 16'hFFFF, and clear on reset.
REQ-031 With SERDES_FRAME_STAT_EN undefined, both ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 SOF, 31 32 33 34 35 36 37 38 39, 29 B1, EOF, S_READY_I=1 -> 9 writes 0x31..0x39 in order, then one S_SUCC_O, no S_FAIL_O.
REQ-033 Same frame with CRC byte B1 changed to B0 -> the same 9 writes, then one S_FAIL_O; STAT_BAD_O=1 when the macro is defined.
REQ-034 SOF, 12 34, EOF -> zero writes, one S_FAIL_O (payload length 0).
REQ-035 SOF, 5 data bytes, SOF, good 9-byte frame, EOF -> 3 writes, S_FAIL_O, then 9 writes, S_SUCC_O.
REQ-036 Good frame with S_READY_I forced 0 while the 4th byte is due -> 3 writes, one S_FAIL_O, no further output until next SOF.
REQ-037 Good frame with RX_VALID_I toggling 0/1 every cycle, then MAX_LEN=4 with a 5-byte payload -> first: 9 writes + S_SUCC_O; second: 4 writes + S_FAIL_O, EOF silent.
